// File: rtl/i2s_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_scheduler
// Purpose  : Sequences an I2S transmit serializer from the system clock.
//            The block divides clk down to the serial bit clock and holds the
//            serializer in reset until a first stereo sample is loaded. It
//            then fetches one sample per frame from a valid/ready stream and
//            presents it on the serializer's parallel inputs at the frame
//            boundary. A missing sample is replaced with zero and counted.
// Ports    : clk, rst          - system clock, synchronous active-high reset
//            enable            - level; start / keep streaming while high
//            s_valid/s_ready   - upstream handshake, s_left/s_right payload
//            sclk_out          - registered bit clock to serializer sclk
//            tx_rst            - serializer reset
//            left_chan/right_chan - serializer parallel inputs
//            frame_strobe      - 1-clk pulse per frame boundary in RUN
//            underrun          - 1-clk pulse when a boundary finds no sample
//            underrun_cnt      - saturating underrun count
//            busy              - high in PRIME and RUN
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx_scheduler #(
    parameter int WIDTH = 16,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_left,
    input  logic [WIDTH-1:0] s_right,
    output logic             sclk_out,
    output logic             tx_rst,
    output logic [WIDTH-1:0] left_chan,
    output logic [WIDTH-1:0] right_chan,
    output logic             frame_strobe,
    output logic             underrun,
    output logic [7:0]       underrun_cnt,
    output logic             busy
);

    localparam int                 c_BIT_W    = $clog2(2*WIDTH+1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(2*WIDTH);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);
    localparam logic [7:0]         c_DIV_LAST = 8'(DIV-1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t             r_state;
    logic [7:0]         r_div_cnt;
    logic               r_sclk;
    logic               r_tx_rst;
    logic               r_s_ready;
    logic [WIDTH-1:0]   r_left;
    logic [WIDTH-1:0]   r_right;
    logic               r_frame_strobe;
    logic               r_underrun;
    logic [7:0]         r_underrun_cnt;
    logic               r_busy;
    logic [WIDTH-1:0]   r_hold_l;
    logic [WIDTH-1:0]   r_hold_r;
    logic               r_hold_valid;
    logic [c_BIT_W-1:0] r_bit_idx;
    logic [1:0]         r_fall_cnt;     // falls seen in PRIME, saturates at 2
    logic               r_loaded;       // first sample written in PRIME
    logic               r_stop_pend;

    logic               w_tick;
    logic               w_rise;
    logic               w_fall;
    logic [7:0]         w_div_next;
    logic               w_sclk_next;
    logic               w_xfer;
    logic               w_boundary;
    logic               w_hold_next;

    assign w_tick      = (r_div_cnt == c_DIV_LAST);
    assign w_rise      = w_tick & ~r_sclk;
    assign w_fall      = w_tick &  r_sclk;
    assign w_div_next  = w_tick ? 8'd0 : r_div_cnt + 8'd1;
    assign w_sclk_next = r_sclk ^ w_tick;
    assign w_xfer      = s_valid & r_s_ready;

    // The rise that enters RUN happens while still in PRIME, so it is
    // naturally excluded; the next rise with bit_idx 0 follows a full wrap.
    assign w_boundary  = (r_state == ST_RUN) & w_rise & (r_bit_idx == '0);

    // s_ready is registered, so a transfer can only occur while the hold
    // register is empty; a boundary empties it in the same edge.
    assign w_hold_next = w_xfer | (r_hold_valid & ~w_boundary);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_div_cnt      <= 8'd0;
            r_sclk         <= 1'b0;
            r_tx_rst       <= 1'b1;
            r_s_ready      <= 1'b0;
            r_left         <= '0;
            r_right        <= '0;
            r_frame_strobe <= 1'b0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= 8'd0;
            r_busy         <= 1'b0;
            r_hold_l       <= '0;
            r_hold_r       <= '0;
            r_hold_valid   <= 1'b0;
            r_bit_idx      <= '0;
            r_fall_cnt     <= 2'd0;
            r_loaded       <= 1'b0;
            r_stop_pend    <= 1'b0;
        end else begin
            r_frame_strobe <= 1'b0;
            r_underrun     <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_sclk       <= 1'b0;
                    r_div_cnt    <= 8'd0;
                    r_tx_rst     <= 1'b1;
                    r_s_ready    <= 1'b0;
                    r_busy       <= 1'b0;
                    r_hold_valid <= 1'b0;
                    r_stop_pend  <= 1'b0;
                    r_fall_cnt   <= 2'd0;
                    r_loaded     <= 1'b0;
                    if (enable) begin
                        r_state   <= ST_PRIME;
                        r_s_ready <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end

                ST_PRIME: begin
                    if (!enable) begin
                        // Abort: any loaded sample is simply forgotten.
                        r_state    <= ST_IDLE;
                        r_sclk     <= 1'b0;
                        r_div_cnt  <= 8'd0;
                        r_s_ready  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_loaded   <= 1'b0;
                        r_fall_cnt <= 2'd0;
                    end else begin
                        r_div_cnt <= w_div_next;
                        r_sclk    <= w_sclk_next;
                        if (w_xfer) begin
                            // Serializer is still in reset, so write straight
                            // to its inputs.
                            r_left    <= s_left;
                            r_right   <= s_right;
                            r_loaded  <= 1'b1;
                            r_s_ready <= 1'b0;
                        end
                        if (w_fall && (r_fall_cnt != 2'd2)) begin
                            r_fall_cnt <= r_fall_cnt + 2'd1;
                        end
                        if (w_rise && r_loaded && (r_fall_cnt == 2'd2)) begin
                            r_state      <= ST_RUN;
                            r_tx_rst     <= 1'b0;
                            r_bit_idx    <= '0;
                            r_hold_valid <= 1'b0;
                            r_s_ready    <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    r_div_cnt    <= w_div_next;
                    r_sclk       <= w_sclk_next;
                    r_hold_valid <= w_hold_next;
                    r_s_ready    <= ~w_hold_next;

                    if (w_xfer) begin
                        r_hold_l <= s_left;
                        r_hold_r <= s_right;
                    end

                    if (w_boundary) begin
                        r_frame_strobe <= 1'b1;
                        if (r_hold_valid) begin
                            r_left  <= r_hold_l;
                            r_right <= r_hold_r;
                        end else begin
                            r_left     <= '0;
                            r_right    <= '0;
                            r_underrun <= 1'b1;
                            if (r_underrun_cnt != 8'hFF) begin
                                r_underrun_cnt <= r_underrun_cnt + 8'd1;
                            end
                        end
                    end

                    if (w_fall) begin
                        r_bit_idx <= (r_bit_idx == c_LAST_BIT) ? '0
                                                               : r_bit_idx + c_BIT_ONE;
                    end

                    // Sticky: re-asserting enable does not cancel the stop.
                    if (!enable) begin
                        r_stop_pend <= 1'b1;
                    end

                    // Stop only on the frame wrap so the serializer always
                    // finishes the frame it is shifting out.
                    if (w_fall && (r_bit_idx == c_LAST_BIT) && r_stop_pend) begin
                        r_state      <= ST_IDLE;
                        r_tx_rst     <= 1'b1;
                        r_hold_valid <= 1'b0;
                        r_stop_pend  <= 1'b0;
                        r_s_ready    <= 1'b0;
                        r_busy       <= 1'b0;
                        r_div_cnt    <= 8'd0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready      = r_s_ready;
    assign sclk_out     = r_sclk;
    assign tx_rst       = r_tx_rst;
    assign left_chan    = r_left;
    assign right_chan   = r_right;
    assign frame_strobe = r_frame_strobe;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_underrun_cnt;
    assign busy         = r_busy;

endmodule
`default_nettype wire
